// File: rtl/stack_pkg.sv
// stack_pkg
//   Shared definitions for the LIFO stack and its stream-side controller.
//   STK_WIDTH / STK_DEPTH are the default word width and capacity used by
//   both the stack and stack_reverser, so the pair agrees by construction.
//   rev_state_t is the controller FSM state encoding.
package stack_pkg;

    localparam int STK_WIDTH = 8;
    localparam int STK_DEPTH = 8;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        POP  = 2'd1,
        LOAD = 2'd2,
        HOLD = 2'd3
    } rev_state_t;

endpackage

// File: rtl/stack_reverser.sv
// stack_reverser
//   Stream-side controller for the stack LIFO. Accepts a framed byte stream,
//   pushes beats into the stack until the frame ends or the stack is full,
//   then pops every stored entry to the output, so each frame (or each
//   DEPTH-sized chunk of a longer frame) leaves in reverse order.
//
// Ports
//   Clk, RstN       clock (rising edge) and asynchronous active-low reset
//   In_Data/In_Valid/In_Last/In_Ready     framed input stream
//   Out_Data/Out_Valid/Out_Last/Out_Ready reversed output stream
//   Stk_Push/Stk_Pop/Stk_Data_In          commands and data to the stack
//   Stk_Data_Out/Stk_Full/Stk_Empty       data and flags from the stack
//   Err             sticky protocol error (stack underflow), reset-only clear
module stack_reverser
    import stack_pkg::*;
#(
    parameter int WIDTH = STK_WIDTH,
    parameter int DEPTH = STK_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    input  logic             In_Last,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Valid,
    output logic             Out_Last,
    input  logic             Out_Ready,
    output logic             Stk_Push,
    output logic             Stk_Pop,
    output logic [WIDTH-1:0] Stk_Data_In,
    input  logic [WIDTH-1:0] Stk_Data_Out,
    input  logic             Stk_Full,
    input  logic             Stk_Empty,
    output logic             Err
);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    rev_state_t       state;
    logic [CW-1:0]    cnt;
    logic             last_q;
    logic [WIDTH-1:0] out_q;
    // Stk_Empty sampled during the POP cycle; the stack updates its flags on
    // the popping edge, so LOAD must look at the pre-pop value.
    logic             empty_q;
    logic             accept;

    assign accept = (state == FILL) && In_Valid && !Stk_Full;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state   <= FILL;
            cnt     <= '0;
            last_q  <= 1'b0;
            out_q   <= '0;
            empty_q <= 1'b0;
            Err     <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        cnt <= cnt + ONE;
                        if (In_Last) begin
                            last_q <= 1'b1;
                            state  <= POP;
                        end else if (cnt == LAST_IDX) begin
                            // Chunk of a longer frame: drain without Out_Last.
                            last_q <= 1'b0;
                            state  <= POP;
                        end
                    end
                end
                POP: begin
                    empty_q <= Stk_Empty;
                    state   <= LOAD;
                end
                LOAD: begin
                    if (empty_q) begin
                        // Underflow: the stack lost entries we counted.
                        Err   <= 1'b1;
                        cnt   <= '0;
                        state <= FILL;
                    end else begin
                        out_q <= Stk_Data_Out;
                        cnt   <= cnt - ONE;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (Out_Ready) begin
                        state <= (cnt == '0) ? FILL : POP;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign In_Ready    = (state == FILL) && !Stk_Full;
    assign Stk_Push    = accept;
    assign Stk_Pop     = (state == POP);
    assign Stk_Data_In = (state == FILL) ? In_Data : '0;
    assign Out_Valid   = (state == HOLD);
    assign Out_Data    = (state == HOLD) ? out_q : '0;
    assign Out_Last    = (state == HOLD) && last_q && (cnt == '0);

endmodule

// File: tb/tb_stack_reverser.sv
// tb_stack_reverser
//   Pairs stack_reverser with a behavioural LIFO and checks the reversed
//   stream through a scoreboard: directed frames push their hand-computed
//   reversed beats into a queue, and a monitor compares every output
//   handshake against the queue head.
module tb_stack_reverser;
    import stack_pkg::*;

    localparam int WIDTH = STK_WIDTH;
    localparam int DEPTH = STK_DEPTH;

    logic             Clk = 1'b0;
    logic             RstN;
    logic [WIDTH-1:0] In_Data;
    logic             In_Valid;
    logic             In_Last;
    logic             In_Ready;
    logic [WIDTH-1:0] Out_Data;
    logic             Out_Valid;
    logic             Out_Last;
    logic             Out_Ready;
    logic             Stk_Push;
    logic             Stk_Pop;
    logic [WIDTH-1:0] Stk_Data_In;
    logic [WIDTH-1:0] Stk_Data_Out;
    logic             Stk_Full;
    logic             Stk_Empty;
    logic             Err;

    always #5 Clk = ~Clk;

    stack_reverser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk          (Clk),
        .RstN         (RstN),
        .In_Data      (In_Data),
        .In_Valid     (In_Valid),
        .In_Last      (In_Last),
        .In_Ready     (In_Ready),
        .Out_Data     (Out_Data),
        .Out_Valid    (Out_Valid),
        .Out_Last     (Out_Last),
        .Out_Ready    (Out_Ready),
        .Stk_Push     (Stk_Push),
        .Stk_Pop      (Stk_Pop),
        .Stk_Data_In  (Stk_Data_In),
        .Stk_Data_Out (Stk_Data_Out),
        .Stk_Full     (Stk_Full),
        .Stk_Empty    (Stk_Empty),
        .Err          (Err)
    );

    // Behavioural stack: push/pop on the edge, popped data held afterwards,
    // flags follow the registered pointer. force_empty fakes an underflow.
    logic [WIDTH-1:0] mem [DEPTH];
    int               sp;
    logic             force_empty;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            sp           <= 0;
            Stk_Data_Out <= '0;
        end else if (Stk_Push && sp != DEPTH) begin
            mem[sp] <= Stk_Data_In;
            sp      <= sp + 1;
        end else if (Stk_Pop && !Stk_Empty) begin
            Stk_Data_Out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end

    assign Stk_Full  = (sp == DEPTH);
    assign Stk_Empty = (sp == 0) || force_empty;

    int total = 0;
    int bad   = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;
    logic [WIDTH:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [WIDTH-1:0] d, input logic l);
        sb.push_back({l, d});
    endtask

    always @(posedge Clk) begin
        if (RstN && Stk_Push) push_cnt++;
        if (RstN && Stk_Pop)  pop_cnt++;
    end

    // Monitor: compares every output handshake with the scoreboard head.
    always @(negedge Clk) begin
        logic [WIDTH:0] e;
        if (RstN) begin
            chk("push_pop_exclusive", 32'(Stk_Push && Stk_Pop), 32'(0));
            if (Out_Valid && Out_Ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got=%0h expected=none", Out_Data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(Out_Data), 32'(e[WIDTH-1:0]));
                    chk("out_last", 32'(Out_Last), 32'(e[WIDTH]));
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int n = 0;
        In_Data  = d;
        In_Valid = 1'b1;
        In_Last  = l;
        @(negedge Clk);
        while (!In_Ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!In_Ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got=stalled expected=accept of %0h", d);
        end
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        In_Data  = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'(0));
        repeat (2) @(posedge Clk);
        #1;
    endtask

    initial begin
        int p0;
        int lat;
        int n;
        logic [WIDTH-1:0] d0;

        RstN        = 1'b0;
        In_Data     = '0;
        In_Valid    = 1'b0;
        In_Last     = 1'b0;
        Out_Ready   = 1'b1;
        force_empty = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_out_valid", 32'(Out_Valid), 32'(0));
        chk("rst_out_last",  32'(Out_Last),  32'(0));
        chk("rst_out_data",  32'(Out_Data),  32'(0));
        chk("rst_push",      32'(Stk_Push),  32'(0));
        chk("rst_pop",       32'(Stk_Pop),   32'(0));
        chk("rst_stk_din",   32'(Stk_Data_In), 32'(0));
        chk("rst_err",       32'(Err),       32'(0));
        chk("rst_in_ready",  32'(In_Ready),  32'(1));
        RstN = 1'b1;
        @(posedge Clk);
        #1;

        // Frame 1,2,3,4 -> 4,3,2,1 with Last on 1.
        expect_beat(8'd4, 1'b0);
        expect_beat(8'd3, 1'b0);
        expect_beat(8'd2, 1'b0);
        expect_beat(8'd1, 1'b1);
        p0 = push_cnt;
        for (int i = 1; i <= 4; i++) send(8'(i), i == 4);
        wait_drain();
        chk("frame4_pushes", 32'(push_cnt - p0), 32'(4));
        chk("frame4_err", 32'(Err), 32'(0));

        // 10-beat frame: first chunk 8..1 without Last, then 10,9 with Last on 9.
        for (int i = 8; i >= 1; i--) expect_beat(8'(i), 1'b0);
        expect_beat(8'd10, 1'b0);
        expect_beat(8'd9, 1'b1);
        for (int i = 1; i <= 10; i++) send(8'(i), i == 10);
        wait_drain();

        // Single beat: Out_Valid two edges after the accepting edge.
        expect_beat(8'hA5, 1'b1);
        send(8'hA5, 1'b1);
        lat = 0;
        while (!Out_Valid && lat < 10) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk("single_latency", 32'(lat), 32'(2));
        wait_drain();

        // Backpressure: hold Out_Ready low for 5 cycles in HOLD.
        expect_beat(8'h33, 1'b0);
        expect_beat(8'h22, 1'b0);
        expect_beat(8'h11, 1'b1);
        Out_Ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        n = 0;
        while (!Out_Valid && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("bp_valid_seen", 32'(Out_Valid), 32'(1));
        d0 = Out_Data;
        chk("bp_first_data", 32'(d0), 32'(8'h33));
        p0 = pop_cnt;
        repeat (5) begin
            @(posedge Clk);
            #1;
            chk("bp_hold_valid", 32'(Out_Valid), 32'(1));
            chk("bp_hold_data",  32'(Out_Data),  32'(d0));
            chk("bp_hold_last",  32'(Out_Last),  32'(0));
        end
        chk("bp_no_extra_pop", 32'(pop_cnt - p0), 32'(0));
        Out_Ready = 1'b1;
        wait_drain();

        // Underflow: stack reports Empty in the POP cycle with cnt = 2.
        force_empty = 1'b1;
        send(8'h31, 1'b0);
        send(8'h32, 1'b1);
        repeat (4) @(posedge Clk);
        #1;
        chk("uf_err",      32'(Err),       32'(1));
        chk("uf_in_ready", 32'(In_Ready),  32'(1));
        chk("uf_no_out",   32'(Out_Valid), 32'(0));
        chk("uf_cnt",      32'(dut.cnt),   32'(0));
        force_empty = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("uf_err_sticky", 32'(Err), 32'(1));
        RstN = 1'b0;
        #1;
        chk("uf_err_cleared", 32'(Err), 32'(0));
        @(posedge Clk);
        #1;
        RstN = 1'b1;
        @(posedge Clk);
        #1;

        // Reset mid-drain after 2 of 4 outputs, then a fresh frame 7,8.
        expect_beat(8'h44, 1'b0);
        expect_beat(8'h43, 1'b0);
        expect_beat(8'h42, 1'b0);
        expect_beat(8'h41, 1'b1);
        for (int i = 1; i <= 4; i++) send(8'(8'h40 + i), i == 4);
        n = 0;
        while (sb.size() > 2 && n < 50) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("mid_two_out", 32'(sb.size()), 32'(2));
        RstN = 1'b0;
        #1;
        sb.delete();
        chk("mid_out_valid", 32'(Out_Valid),   32'(0));
        chk("mid_out_last",  32'(Out_Last),    32'(0));
        chk("mid_out_data",  32'(Out_Data),    32'(0));
        chk("mid_pop",       32'(Stk_Pop),     32'(0));
        chk("mid_push",      32'(Stk_Push),    32'(0));
        chk("mid_stk_din",   32'(Stk_Data_In), 32'(0));
        chk("mid_cnt",       32'(dut.cnt),     32'(0));
        @(posedge Clk);
        #1;
        RstN = 1'b1;
        @(posedge Clk);
        #1;
        expect_beat(8'd8, 1'b0);
        expect_beat(8'd7, 1'b1);
        send(8'd7, 1'b0);
        send(8'd8, 1'b1);
        wait_drain();
        chk("final_err", 32'(Err), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
